// File: rtl/mw_add_pkg.sv
// mw_add_pkg: shared types and constants for the multi-word add/subtract
// sequencer.
//   WORD_W    : width of one slice handled by the shared ripple-carry adder
//   MAX_WORDS : largest supported slice count
//   state_t   : sequencer FSM states
package mw_add_pkg;

    localparam int WORD_W    = 32;
    localparam int MAX_WORDS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mw_add_ctrl_if.sv
// mw_add_ctrl_if: request/response bundle of the multi-word add sequencer.
//   request  : in_valid, in_ready, a, b, sub
//   response : out_valid, out_ready, result, cout, ovf
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holds valid and its payload stable until that edge;
// ready never depends combinationally on valid.
//   master : requester + consumer side (drives in_valid/a/b/sub/out_ready)
//   slave  : sequencer side
interface mw_add_ctrl_if #(
    parameter int WORDS = 4
);
    import mw_add_pkg::*;

    localparam int W = WORD_W * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result, cout, ovf
    );

endinterface

// File: rtl/rca_32bit.sv
// rca_32bit: plain 32-bit ripple-carry adder.
//   a, b : addends
//   cin  : carry in
//   sum  : a + b + cin (low 32 bits)
//   cout : carry out of bit 31
module rca_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic cy;

    // Bit-serial ripple: the carry is walked through the loop so each bit
    // sees the carry produced by the bit below it.
    always_comb begin
        cy  = cin;
        sum = '0;
        for (int i = 0; i < 32; i++) begin
            sum[i] = a[i] ^ b[i] ^ cy;
            cy     = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
        end
        cout = cy;
    end

endmodule

// File: rtl/mw_add_ctrl.sv
// mw_add_ctrl: WORDS x 32-bit add/subtract built from one shared 32-bit
// ripple-carry adder, one slice per cycle, LSB slice first.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : request/response handshake (slave side)
//   dbg_state : current FSM state
// Parameter WORDS: slice count, legal range 2..MAX_WORDS.
module mw_add_ctrl
    import mw_add_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic            clk,
    input  logic            rst,
    mw_add_ctrl_if.slave    bus,
    output state_t          dbg_state
);

    localparam int W     = WORD_W * WORDS;
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       beff_q;
    logic [W-1:0]       result_q;
    logic               cout_q;
    logic               ovf_q;

    logic [WORD_W-1:0]  slice_a;
    logic [WORD_W-1:0]  slice_b;
    logic [WORD_W-1:0]  slice_sum;
    logic               slice_cout;
    logic               last_slice;

    assign last_slice = (idx_q == LAST_IDX);
    assign slice_a    = a_q[WORD_W*idx_q +: WORD_W];
    assign slice_b    = beff_q[WORD_W*idx_q +: WORD_W];

    rca_32bit u_rca (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_valid) state_d = RUN;
            RUN:     if (last_slice)   state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from registered state only.
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
    end

    // Datapath. Subtraction is a + ~b + 1: b is inverted at capture and the
    // +1 enters as the initial carry, so the adder itself never knows.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            beff_q   <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        beff_q  <= bus.sub ? ~bus.b : bus.b;
                        carry_q <= bus.sub;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    result_q[WORD_W*idx_q +: WORD_W] <= slice_sum;
                    carry_q <= slice_cout;
                    if (last_slice) begin
                        cout_q <= slice_cout;
                        // Overflow: both operands agree in sign, result differs.
                        ovf_q  <= (a_q[W-1] ^ slice_sum[WORD_W-1]) &
                                  (beff_q[W-1] ^ slice_sum[WORD_W-1]);
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.ovf    = ovf_q;
    assign dbg_state  = state_q;

endmodule

// File: doc/mw_add_ctrl.md
# mw_add_ctrl

Multi-word add/subtract sequencer. It computes a WORDS×32-bit sum or difference by driving one shared `rca_32bit` instance for WORDS consecutive cycles, one 32-bit slice per cycle, LSB slice first. The carry is kept in a register between cycles. The block sits between a requester and a consumer using valid/ready handshakes, so wide arithmetic reuses the existing 32-bit ripple-carry datapath instead of instantiating a wider adder.

## Interface
Parameters:
- WORDS, 4, number of 32-bit slices; legal range 2..16; operand width W = 32*WORDS.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  requester presents an operation.
- in_ready  output  1  block accepts an operation; high only in IDLE.
- a  input  W  first operand.
- b  input  W  second operand.
- sub  input  1  0: a+b; 1: a−b.
- out_valid  output  1  result available; held until accepted.
- out_ready  input  1  consumer accepts result.
- result  output  W  sum or difference, mod 2^W.
- cout  output  1  final carry out of the MSB slice; for subtract, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE:**
  - in_ready=1.
  - When in_valid=1, capture a, the effective operand b_eff (b if sub=0, ~b if sub=1) and sub.
  - Set idx=0, carry=sub, then go to RUN.
- **RUN:**
  - The adder receives a[32*idx +: 32], b_eff[32*idx +: 32] and cin=carry.
  - On each edge:
    - store the adder sum into result[32*idx +: 32];
    - carry ← adder cout;
    - idx ← idx+1.
  - When idx==WORDS−1, go to DONE on that edge instead of incrementing.
  - On that same edge, cout ← adder cout and ovf ← (a[W−1] ^ s) & (b_eff[W−1] ^ s), where s is the MSB of the adder sum.
- **DONE:**
  - out_valid=1; result, cout and ovf are held stable.
  - When out_ready=1, return to IDLE and clear out_valid.
- in_ready is 0 throughout RUN and DONE. in_valid in those states is ignored and is not queued.
- In DONE with in_valid=1 and out_ready=1 on the same cycle, the block does not accept the new operation that cycle. It accepts it in IDLE on the next cycle.
- Operands are captured only at acceptance. Changes on a, b or sub after acceptance have no effect.
- result slices not yet written in RUN keep their previous values. result is not defined as valid until out_valid=1.
- idx is $clog2(WORDS) bits wide and never wraps past WORDS−1.

## Timing
- **Reset values:**
  - state=IDLE, so in_ready=1 in the first cycle after reset.
  - out_valid=0, result=0, cout=0, ovf=0, idx=0, carry=0.
- Reset has priority over every other input. Reset asserted in RUN or DONE aborts the operation and discards the pending result.
- **Latency:**
  - Acceptance edge is T (in_valid & in_ready).
  - out_valid rises after edge T+WORDS. For WORDS=4, it is visible in the cycle following edge T+4.
- Throughput: one operation per WORDS+2 cycles with out_ready held high (accept, WORDS RUN edges, one DONE cycle, one IDLE cycle).
- in_ready and out_valid are decoded from registered state only. There is no combinational path from in_valid or out_ready to any output.
- The critical path is one 32-bit ripple chain plus slice muxing. W-bit carry propagation never occurs in a single cycle.

## Structure
- **Package `mw_add_pkg`:**
  - WORD_W=32.
  - The state enum {IDLE, RUN, DONE}.
  - MAX_WORDS=16.
- **Sub-module:** exactly one `rca_32bit` instance, the existing 32-bit adder, used unchanged. The slice multiplexing, carry register and FSM live in `mw_add_ctrl`.

## Test plan
All scenarios use WORDS=4.

1. Carry through every slice:
   - Stimulus: a=2^128−1, b=1, sub=0.
   - Required: result=0, cout=1, ovf=0, out_valid after exactly 4 edges from acceptance.
2. Subtract with borrow:
   - Stimulus: a=5, b=7, sub=1.
   - Required: result=2^128−2, cout=0, ovf=0.
   - Also a=7, b=5, sub=1 → result=2, cout=1.
3. Signed overflow:
   - Stimulus: a=0x7FFF…FFFF, b=1, sub=0.
   - Required: result=0x8000…0000, ovf=1, cout=0.
   - Also a=0x8000…0000, b=1, sub=1 → ovf=1.
4. Back-pressure:
   - Stimulus: hold out_ready=0 for 10 cycles in DONE while in_valid=1 with new operands.
   - Required: result, cout and ovf are stable; in_ready=0; no capture.
   - On out_ready=1, the block returns to IDLE; the next operation is accepted one cycle later and computed correctly.
5. Reset mid-operation:
   - Stimulus: assert rst on the second RUN edge.
   - Required: the next cycle shows out_valid=0, in_ready=1, result=0.
   - A following a=0x1_00000000, b=0xFFFFFFFF, sub=0 gives result=0x1_FFFFFFFF, cout=0.
6. Operand change after acceptance:
   - Stimulus: accept a=3, b=4, then drive a and b to random values during RUN.
   - Required: result=7.
